// File: rtl/render_rect_gen.sv
// Rectangle pixel-stream generator: scans a latched rectangle row-major, one pixel per unstalled cycle.
// Border colouring is compiled in only when RENDER_RECT_BORDER_EN is defined.
module render_rect_gen #(
    parameter int unsigned X_W      = 9,
    parameter int unsigned Y_W      = 8,
    parameter int unsigned COLOR_W  = 3,
    parameter int unsigned SCREEN_W = 320,
    parameter int unsigned SCREEN_H = 240,
    parameter int unsigned BW_W     = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_W-1:0]     origin_x,
    input  logic [Y_W-1:0]     origin_y,
    input  logic [X_W-1:0]     width,
    input  logic [Y_W-1:0]     height,
    input  logic [COLOR_W-1:0] back_color,
    input  logic [BW_W-1:0]    border_w,
    input  logic [COLOR_W-1:0] border_color,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic [X_W-1:0]     x_stream,
    output logic [Y_W-1:0]     y_stream,
    output logic [COLOR_W-1:0] color_stream,
    output logic               writeEn
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [X_W-1:0]     col_q, col_d;
    logic [Y_W-1:0]     row_q, row_d;
    logic [X_W-1:0]     ox_q, ox_d;
    logic [Y_W-1:0]     oy_q, oy_d;
    logic [X_W-1:0]     w_q, w_d;
    logic [Y_W-1:0]     h_q, h_d;
    logic [COLOR_W-1:0] back_q, back_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               vis_q, vis_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               latch_en;
    logic [X_W-1:0]     s_ox, s_w;
    logic [Y_W-1:0]     s_oy, s_h;
    logic [COLOR_W-1:0] s_back;
    logic [X_W-1:0]     pc;
    logic [Y_W-1:0]     pr;
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;
    logic               pix_vis;
    logic [COLOR_W-1:0] pix_color;
    logic               last_pix;

    // Attributes feeding the pixel calculator: live inputs on the latching edge, latched copies otherwise
    always_comb begin
        latch_en = (state_q == ST_IDLE) && start;
        s_ox     = latch_en ? origin_x   : ox_q;
        s_oy     = latch_en ? origin_y   : oy_q;
        s_w      = latch_en ? width      : w_q;
        s_h      = latch_en ? height     : h_q;
        s_back   = latch_en ? back_color : back_q;
    end

    // Coordinates of the pixel that becomes current after this edge
    always_comb begin
        last_pix = (col_q == w_q - X_W'(1)) && (row_q == h_q - Y_W'(1));
        if (state_q != ST_DRAW) begin
            pc = '0;
            pr = '0;
        end else if (col_q == w_q - X_W'(1)) begin
            pc = '0;
            pr = row_q + Y_W'(1);
        end else begin
            pc = col_q + X_W'(1);
            pr = row_q;
        end
        sum_x   = {1'b0, s_ox} + {1'b0, pc};
        sum_y   = {1'b0, s_oy} + {1'b0, pr};
        pix_vis = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
    end

`ifdef RENDER_RECT_BORDER_EN
    localparam int unsigned XE = ((X_W > BW_W) ? X_W : BW_W) + 1;
    localparam int unsigned YE = ((Y_W > BW_W) ? Y_W : BW_W) + 1;

    logic [BW_W-1:0]    bw_q, bw_d, s_bw;
    logic [COLOR_W-1:0] bcol_q, bcol_d, s_bcol;
    logic               pix_border;

    // col >= width-bw is tested as col+bw >= width so a thick border never underflows
    always_comb begin
        s_bw       = latch_en ? border_w     : bw_q;
        s_bcol     = latch_en ? border_color : bcol_q;
        bw_d       = s_bw;
        bcol_d     = s_bcol;
        pix_border = (s_bw != '0) &&
                     ((XE'(pc) < XE'(s_bw)) || ((XE'(pc) + XE'(s_bw)) >= XE'(s_w)) ||
                      (YE'(pr) < YE'(s_bw)) || ((YE'(pr) + YE'(s_bw)) >= YE'(s_h)));
        pix_color  = pix_border ? s_bcol : s_back;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bw_q   <= '0;
            bcol_q <= '0;
        end else begin
            bw_q   <= bw_d;
            bcol_q <= bcol_d;
        end
    end
`else
    logic unused_border;
    assign unused_border = ^{border_w, border_color};

    always_comb begin
        pix_color = s_back;
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ox_d    = s_ox;
        oy_d    = s_oy;
        w_d     = s_w;
        h_d     = s_h;
        back_d  = s_back;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        vis_d   = vis_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    col_d = '0;
                    row_d = '0;
                    if ((width == '0) || (height == '0)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        vis_d   = 1'b0;
                    end else begin
                        state_d = ST_DRAW;
                        busy_d  = 1'b1;
                        x_d     = sum_x[X_W-1:0];
                        y_d     = sum_y[Y_W-1:0];
                        color_d = pix_color;
                        vis_d   = pix_vis;
                    end
                end
            end
            ST_DRAW: begin
                if (!start) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    vis_d   = 1'b0;
                end else if (!hold) begin
                    if (last_pix) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        vis_d   = 1'b0;
                    end else begin
                        col_d   = pc;
                        row_d   = pr;
                        x_d     = sum_x[X_W-1:0];
                        y_d     = sum_y[Y_W-1:0];
                        color_d = pix_color;
                        vis_d   = pix_vis;
                    end
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                vis_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            back_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            vis_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            w_q     <= w_d;
            h_q     <= h_d;
            back_q  <= back_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            vis_q   <= vis_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A stall suppresses the strobe in the same cycle
    assign writeEn      = vis_q & ~hold;
    assign busy         = busy_q;
    assign done         = done_q;
    assign x_stream     = x_q;
    assign y_stream     = y_q;
    assign color_stream = color_q;

endmodule

// File: tb/tb_render_rect_gen.sv
// Bench for render_rect_gen: pixel-index reference model checked every cycle plus directed literal checks.
module tb_render_rect_gen;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;
    localparam int BWW = 4;

    logic          clk = 1'b0;
    logic          resetn, start, hold;
    logic [XW-1:0] origin_x, width;
    logic [YW-1:0] origin_y, height;
    logic [CW-1:0] back_color, border_color;
    logic [BWW-1:0] border_w;
    logic          busy, done, writeEn;
    logic [XW-1:0] x_stream;
    logic [YW-1:0] y_stream;
    logic [CW-1:0] color_stream;

    render_rect_gen dut (
        .clk(clk), .resetn(resetn), .start(start),
        .origin_x(origin_x), .origin_y(origin_y), .width(width), .height(height),
        .back_color(back_color), .border_w(border_w), .border_color(border_color),
        .hold(hold), .busy(busy), .done(done),
        .x_stream(x_stream), .y_stream(y_stream), .color_stream(color_stream),
        .writeEn(writeEn)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: draw progress is a linear pixel index into the latched rectangle
    int m_mode = 0;   // 0 idle, 1 drawing, 2 finished
    int m_idx = 0;
    int m_ox, m_oy, m_w, m_h, m_back, m_bw, m_bcol;

    always @(posedge clk) begin
        if (!resetn) begin
            m_mode = 0;
            m_idx  = 0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_ox = origin_x; m_oy = origin_y; m_w = width; m_h = height;
                    m_back = back_color; m_bw = border_w; m_bcol = border_color;
                    m_idx = 0;
                    m_mode = (width == 0 || height == 0) ? 2 : 1;
                end
                1: if (!start) m_mode = 0;
                   else if (!hold) begin
                       if (m_idx == m_w * m_h - 1) m_mode = 2;
                       else m_idx++;
                   end
                default: if (!start) m_mode = 0;
            endcase
        end
    end

    function automatic int exp_color(input int col, input int row);
`ifdef RENDER_RECT_BORDER_EN
        if (m_bw != 0 && (col < m_bw || col >= m_w - m_bw || row < m_bw || row >= m_h - m_bw))
            return m_bcol;
`endif
        return m_back;
    endfunction

    int lx[$];
    int ly[$];
    int lc[$];
    int busy_cnt = 0;
    int done_cnt = 0;
    int e_col, e_row, e_x, e_y;
    bit e_vis;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 32'(busy), 32'(m_mode == 1));
            chk("done", 32'(done), 32'(m_mode == 2));
            e_vis = 1'b0;
            if (m_mode == 1) begin
                e_col = m_idx % m_w;
                e_row = m_idx / m_w;
                e_x   = m_ox + e_col;
                e_y   = m_oy + e_row;
                e_vis = (e_x < 320) && (e_y < 240);
                chk("x_stream", 32'(x_stream), 32'(e_x % 512));
                chk("y_stream", 32'(y_stream), 32'(e_y % 256));
                chk("color_stream", 32'(color_stream), 32'(exp_color(e_col, e_row)));
            end
            chk("writeEn", 32'(writeEn), 32'(e_vis && !hold));
            if (writeEn === 1'b1) begin
                lx.push_back(int'(x_stream));
                ly.push_back(int'(y_stream));
                lc.push_back(int'(color_stream));
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic set_rect(input int ox, input int oy, input int w, input int h,
                            input int bw, input int bc, input int bdc);
        origin_x = XW'(ox); origin_y = YW'(oy); width = XW'(w); height = YW'(h);
        border_w = BWW'(bw); back_color = CW'(bc); border_color = CW'(bdc);
        lx.delete(); ly.delete(); lc.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_start();
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    int bc_exp;

    initial begin
        resetn = 1'b0; start = 1'b0; hold = 1'b0;
        set_rect(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_x", 32'(x_stream), 32'd0);
        chk("rst_y", 32'(y_stream), 32'd0);
        chk("rst_color", 32'(color_stream), 32'd0);
        chk("rst_writeEn", 32'(writeEn), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // 4x3 at (10,20), 1-pixel border
        set_rect(10, 20, 4, 3, 1, 2, 5);
        start = 1'b1;
        wait_done(100);
`ifdef RENDER_RECT_BORDER_EN
        bc_exp = 5;
`else
        bc_exp = 2;
`endif
        chk("rect_writes", 32'(lx.size()), 32'd12);
        if (lx.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                chk("rect_x", 32'(lx[i]), 32'(10 + i % 4));
                chk("rect_y", 32'(ly[i]), 32'(20 + i / 4));
                chk("rect_color", 32'(lc[i]), 32'((i == 5 || i == 6) ? 2 : bc_exp));
            end
        end
        release_start();

        // Bottom-right screen corner clipping
        set_rect(318, 239, 4, 2, 0, 6, 0);
        start = 1'b1;
        wait_done(100);
        chk("clip_writes", 32'(lx.size()), 32'd2);
        if (lx.size() == 2) begin
            chk("clip_x0", 32'(lx[0]), 32'd318);
            chk("clip_y0", 32'(ly[0]), 32'd239);
            chk("clip_x1", 32'(lx[1]), 32'd319);
            chk("clip_y1", 32'(ly[1]), 32'd239);
        end
        chk("clip_draw_cycles", 32'(busy_cnt), 32'd8);
        release_start();

        // 3x3 with a 3-cycle stall on pixel 5
        set_rect(0, 0, 3, 3, 0, 1, 0);
        start = 1'b1;
        repeat (6) @(posedge clk);
        #1 hold = 1'b1;
        @(negedge clk);
        chk("hold_x", 32'(x_stream), 32'd2);
        chk("hold_y", 32'(y_stream), 32'd1);
        chk("hold_writeEn", 32'(writeEn), 32'd0);
        repeat (3) @(posedge clk);
        #1 hold = 1'b0;
        wait_done(100);
        chk("hold_writes", 32'(lx.size()), 32'd9);
        if (lx.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk("hold_seq_x", 32'(lx[i]), 32'(i % 3));
                chk("hold_seq_y", 32'(ly[i]), 32'(i / 3));
            end
        end
        release_start();

        // Abort 8x8 after 4 pixels, then redraw fully
        set_rect(100, 100, 8, 8, 0, 3, 0);
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_writeEn", 32'(writeEn), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_writes", 32'(lx.size()), 32'd4);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        set_rect(100, 100, 8, 8, 0, 3, 0);
        start = 1'b1;
        wait_done(200);
        chk("redraw_writes", 32'(lx.size()), 32'd64);
        release_start();

        // Zero width goes straight to done
        set_rect(50, 50, 0, 5, 0, 4, 0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_writes", 32'(lx.size()), 32'd0);
        release_start();

        // Reset mid-draw overrides start and hold
        set_rect(10, 20, 4, 3, 0, 7, 0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0; hold = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_x", 32'(x_stream), 32'd0);
        chk("mid_rst_y", 32'(y_stream), 32'd0);
        chk("mid_rst_color", 32'(color_stream), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_writeEn", 32'(writeEn), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1; hold = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/render_rect_gen.md
RENDER_RECT_GEN -- requirements
Module: render_rect_gen

Interface
REQ-001 SHALL have parameter X_W, default 9, x coordinate/width bit width.
REQ-002 SHALL have parameter Y_W, default 8, y coordinate/height bit width.
REQ-003 SHALL have parameter COLOR_W, default 3, color bit width.
REQ-004 SHALL have parameter SCREEN_W, default 320, visible columns.
REQ-005 SHALL have parameter SCREEN_H, default 240, visible rows.
REQ-006 SHALL have parameter BW_W, default 4, border thickness bit width.
REQ-007 Ports (name direction width meaning): clk in 1 clock; resetn in 1 synchronous active-low reset.
REQ-008 start in 1 level draw request; origin_x in X_W rect left; origin_y in Y_W rect top.
REQ-009 width in X_W columns; height in Y_W rows; back_color in COLOR_W fill color.
REQ-010 border_w in BW_W border thickness in pixels; border_color in COLOR_W border color.
REQ-011 hold in 1 downstream stall; busy out 1 drawing; done out 1 drawing complete.
REQ-012 x_stream out X_W, y_stream out Y_W, color_stream out COLOR_W pixel stream; writeEn out 1 VGA write strobe.
REQ-013 One clock; reset is synchronous and active-low, ports named clk and resetn.

Function
REQ-014 FSM states SHALL be IDLE, DRAW, DONE.
REQ-015 IDLE: on edge with start=1, latch all rect attributes, clear col/row counters, go DRAW; if width=0 or height=0 go DONE directly.
REQ-016 Latched attributes SHALL be used for the whole draw; input changes during DRAW have no effect.
REQ-017 DRAW: current pixel is (col,row); x_stream=origin_x+col, y_stream=origin_y+row (truncated to X_W/Y_W), registered.
REQ-018 Scan order SHALL be row-major: col 0..width-1, then row+1; one pixel per unstalled cycle.
REQ-019 Counters SHALL advance only on edges with hold=0; with hold=1, outputs and counters frozen.
REQ-020 writeEn SHALL equal (state==DRAW) & visible & ~hold (hold gating combinational).
REQ-021 visible SHALL be origin_x+col < SCREEN_W and origin_y+row < SCREEN_H, computed one bit wider than X_W/Y_W; off-screen pixels consume a cycle with writeEn=0.
REQ-022 Pixel is border if border_w!=0 and (col<border_w or col>=width-border_w or row<border_w or row>=height-border_w); 2*border_w>=width or height makes all pixels border.
REQ-023 color_stream SHALL be border_color for border pixels, else back_color.
REQ-024 After unstalled last pixel (col=width-1,row=height-1) go DONE; total unstalled DRAW cycles = width*height.
REQ-025 DONE: done=1, busy=0, writeEn=0; remain until start=0, then IDLE on next edge.
REQ-026 start=0 during DRAW SHALL abort: IDLE next edge, writeEn=0, done stays 0.
REQ-027 busy SHALL be 1 exactly in DRAW.

Reset
REQ-028 On edge with resetn=0: state IDLE, counters 0, x_stream/y_stream/color_stream 0, busy 0, done 0, writeEn 0.
REQ-029 Reset SHALL dominate start and hold, including mid-DRAW.

Configuration
REQ-030 With RENDER_RECT_BORDER_EN defined, border logic per REQ-022/023 SHALL be compiled in.
REQ-031 Without RENDER_RECT_BORDER_EN, border_w/border_color ignored, every pixel back_color, no border comparators synthesised.

Verification
REQ-032 origin (10,20), 4x3, border_w=1, start held -> 12 writes row-major, x 10..13, y 20..22, only (11,21),(12,21) back_color, then done=1.
REQ-033 origin (318,239), 4x2 -> writes only (318,239),(319,239); 8 DRAW cycles; done asserted.
REQ-034 hold=1 for 3 cycles at pixel 5 of 3x3 -> outputs frozen, writeEn=0 those cycles, still exactly 9 writes, no duplicates/skips.
REQ-035 start dropped after 4 pixels of 8x8 -> writeEn=0 next cycle, IDLE, done never asserted; restart draws full 64.
REQ-036 width=0 -> no writes, done=1 one cycle after start; resetn=0 mid-DRAW -> all outputs 0 next edge.
REQ-037 Build without RENDER_RECT_BORDER_EN, 4x3 border_w=1 -> all 12 pixels back_color.
